// File: rtl/ex_redirect_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ex_redirect_ctrl: EX-stage redirect/halt FSM with stall and flush merging.  |
// | Optional redirect counter enabled by EX_REDIRECT_PERF_EN.  Rev 1.0          |
// +----------------------------------------------------------------------------+
module ex_redirect_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int PC_W         = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_redirect,
    input  logic [PC_W-1:0] ex_target,
    input  logic            ex_halt,
    input  logic            lu_hazard,
    input  logic            mem_busy,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_target,
    output logic            pc_stall,
    output logic            if_id_stall,
    output logic            if_id_flush,
    output logic            id_ex_stall,
    output logic            id_ex_flush,
    output logic            ex_mem_stall,
    output logic            halted,
    output logic [15:0]     redirect_cnt
);

    localparam logic [3:0] C_CNT_INIT = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [PC_W-1:0] target_q, target_d;
    logic            first_q, first_d;
`ifdef EX_REDIRECT_PERF_EN
    logic            redir_take;
    logic [15:0]     redirect_cnt_q, redirect_cnt_d;
`endif

    // mem_busy freezes every piece of state, so a pending pc_load survives the stall
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        first_d  = first_q;
`ifdef EX_REDIRECT_PERF_EN
        redir_take = 1'b0;
`endif
        if (!mem_busy) begin
            case (state_q)
                ST_RUN: begin
                    if (ex_valid && ex_halt) begin
                        state_d = ST_HALT;
                    end else if (ex_valid && ex_redirect) begin
                        state_d  = ST_FLUSH;
                        target_d = ex_target;
                        cnt_d    = C_CNT_INIT;
                        first_d  = 1'b1;
`ifdef EX_REDIRECT_PERF_EN
                        redir_take = 1'b1;
`endif
                    end
                end
                ST_FLUSH: begin
                    first_d = 1'b0;
                    if (cnt_q == 4'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            cnt_q    <= 4'd0;
            target_q <= '0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            first_q  <= first_d;
        end
    end

    // Stall outputs are combinational from inputs, so reset must gate them explicitly
    always_comb begin
        pc_load      = 1'b0;
        pc_target    = '0;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        halted       = 1'b0;
        if (rst_n) begin
            pc_target = target_q;
            halted    = (state_q == ST_HALT);
            if (mem_busy) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (lu_hazard) begin
                            pc_stall    = 1'b1;
                            if_id_stall = 1'b1;
                            id_ex_flush = 1'b1;
                        end
                    end
                    ST_FLUSH: begin
                        pc_load     = first_q;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                    ST_HALT: begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                    end
                    default: begin
                        pc_load = 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef EX_REDIRECT_PERF_EN
    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        if (redir_take && (redirect_cnt_q != 16'hFFFF)) begin
            redirect_cnt_d = redirect_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt_q <= 16'h0000;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign redirect_cnt = rst_n ? redirect_cnt_q : 16'h0000;
`else
    assign redirect_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire
